// File: rtl/uart_time_set_rx.sv
// Parses "S" + 14 ASCII digits + optional CR + LF from a byte stream into a
// 56-bit BCD time/date word {YY,WW,MM,DD,hh,mm,ss}, with range and gap checks.
module uart_time_set_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int TIMEOUT_MS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_vld,
  output logic [55:0] dout,
  output logic        dout_vld,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam int TO_CYC = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int GW     = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(TO_CYC - 1);

  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  localparam logic [1:0] ERR_CHAR  = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_TIME  = 2'd3;

  typedef enum logic [1:0] {IDLE, DIGIT, TERM, CHECK} state_t;

  state_t        state, next_state;
  logic [55:0]   shift_reg;
  logic [3:0]    digit_cnt;
  logic          cr_seen;
  logic [GW-1:0] gap_cnt;

  logic          frame_start, digit_shift, cr_set, dout_load, err_set;
  logic [1:0]    err_code_nxt;

  logic          is_digit, in_frame, gap_expired, range_ok;
  logic [7:0]    f_ww, f_mm, f_dd, f_hh, f_mi, f_ss;

  assign is_digit    = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign in_frame    = (state == DIGIT) || (state == TERM);
  assign gap_expired = in_frame && !rx_vld && (gap_cnt == GAP_LAST);
  assign busy        = (state != IDLE);

  // Every nibble is a decimal digit, so BCD bytes order the same as hex.
  assign f_ww = shift_reg[47:40];
  assign f_mm = shift_reg[39:32];
  assign f_dd = shift_reg[31:24];
  assign f_hh = shift_reg[23:16];
  assign f_mi = shift_reg[15:8];
  assign f_ss = shift_reg[7:0];
  assign range_ok = (f_ww >= 8'h01) && (f_ww <= 8'h07) &&
                    (f_mm >= 8'h01) && (f_mm <= 8'h12) &&
                    (f_dd >= 8'h01) && (f_dd <= 8'h31) &&
                    (f_hh <= 8'h23) && (f_mi <= 8'h59) && (f_ss <= 8'h59);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (rx_vld && rx_data == CH_S) next_state = DIGIT;
      DIGIT: begin
        if (rx_vld) begin
          if (is_digit)              next_state = (digit_cnt == 4'd13) ? TERM : DIGIT;
          else if (rx_data != CH_S)  next_state = IDLE;
        end else if (gap_expired) begin
          next_state = IDLE;
        end
      end
      TERM: begin
        if (rx_vld) begin
          if (rx_data == CH_LF)                     next_state = CHECK;
          else if (!(rx_data == CH_CR && !cr_seen)) next_state = IDLE;
        end else if (gap_expired) begin
          next_state = IDLE;
        end
      end
      CHECK:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    frame_start  = 1'b0;
    digit_shift  = 1'b0;
    cr_set       = 1'b0;
    dout_load    = 1'b0;
    err_set      = 1'b0;
    err_code_nxt = ERR_CHAR;
    case (state)
      IDLE: frame_start = rx_vld && (rx_data == CH_S);
      DIGIT: begin
        if (rx_vld) begin
          if (is_digit)              digit_shift = 1'b1;
          else if (rx_data == CH_S)  frame_start = 1'b1;
          else                       err_set     = 1'b1;
        end else if (gap_expired) begin
          err_set      = 1'b1;
          err_code_nxt = ERR_TIME;
        end
      end
      TERM: begin
        if (rx_vld) begin
          if (rx_data == CH_CR && !cr_seen) cr_set  = 1'b1;
          else if (rx_data != CH_LF)        err_set = 1'b1;
        end else if (gap_expired) begin
          err_set      = 1'b1;
          err_code_nxt = ERR_TIME;
        end
      end
      CHECK: begin
        if (range_ok) begin
          dout_load = 1'b1;
        end else begin
          err_set      = 1'b1;
          err_code_nxt = ERR_RANGE;
        end
      end
      default: ;
    endcase
  end

  // Datapath: shift register, counters and the registered output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      digit_cnt <= '0;
      cr_seen   <= 1'b0;
      gap_cnt   <= '0;
      dout      <= '0;
      dout_vld  <= 1'b0;
      err       <= 1'b0;
      err_code  <= '0;
    end else begin
      dout_vld <= dout_load;
      err      <= err_set;
      if (err_set)   err_code <= err_code_nxt;
      if (dout_load) dout     <= shift_reg;
      if (digit_shift) shift_reg <= {shift_reg[51:0], rx_data[3:0]};
      if (frame_start) begin
        digit_cnt <= '0;
        cr_seen   <= 1'b0;
      end else begin
        if (digit_shift) digit_cnt <= digit_cnt + 4'd1;
        if (cr_set)      cr_seen   <= 1'b1;
      end
      if (in_frame && !rx_vld) gap_cnt <= gap_cnt + GW'(1);
      else                     gap_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_uart_time_set_rx.sv
// Self-checking bench for uart_time_set_rx: a byte-level frame model predicts
// every output each cycle, plus literal checks on selected frames.
module tb_uart_time_set_rx;

  localparam int CLK_FREQ   = 100_000;
  localparam int TIMEOUT_MS = 1;
  localparam int TO_CYC     = CLK_FREQ / 1000 * TIMEOUT_MS;

  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_vld = 1'b0;
  logic [55:0] dout;
  logic        dout_vld;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;

  uart_time_set_rx #(.CLK_FREQ(CLK_FREQ), .TIMEOUT_MS(TIMEOUT_MS)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_vld(rx_vld),
    .dout(dout), .dout_vld(dout_vld), .err(err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int vld_seen = 0;
  int err_seen = 0;

  bit          model_ready = 1'b0;
  bit          m_in_frame = 1'b0, m_check = 1'b0, m_cr = 1'b0;
  int          m_nd = 0, m_idle = 0;
  int          digs [14];
  logic [55:0] exp_dout = '0;
  logic [1:0]  exp_code = '0;
  bit          exp_vld = 1'b0, exp_err = 1'b0, exp_busy = 1'b0;

  function automatic int field(input int i);
    return digs[2*i] * 10 + digs[2*i+1];
  endfunction

  function automatic bit frame_ok();
    return field(1) >= 1 && field(1) <= 7 && field(2) >= 1 && field(2) <= 12 &&
           field(3) >= 1 && field(3) <= 31 && field(4) <= 23 &&
           field(5) <= 59 && field(6) <= 59;
  endfunction

  function automatic logic [55:0] packed_time();
    logic [55:0] v = '0;
    for (int i = 0; i < 14; i++) v = (v << 4) | 56'(digs[i]);
    return v;
  endfunction

  // Frame model: works on whole bytes and idle-cycle counts, not states.
  always @(posedge clk) begin
    model_ready = 1'b1;
    exp_vld = 1'b0;
    exp_err = 1'b0;
    if (rst) begin
      m_in_frame = 1'b0; m_check = 1'b0; m_cr = 1'b0; m_nd = 0; m_idle = 0;
      exp_dout = '0; exp_code = '0;
    end else if (m_check) begin
      m_check = 1'b0;
      if (frame_ok()) begin exp_vld = 1'b1; exp_dout = packed_time(); end
      else begin exp_err = 1'b1; exp_code = 2'd2; end
    end else if (m_in_frame) begin
      if (rx_vld) begin
        m_idle = 0;
        if (m_nd < 14 && rx_data >= 8'h30 && rx_data <= 8'h39) begin
          digs[m_nd] = int'(rx_data) - 48;
          m_nd++;
        end else if (m_nd < 14 && rx_data == CH_S) m_nd = 0;
        else if (m_nd == 14 && rx_data == CH_CR && !m_cr) m_cr = 1'b1;
        else if (m_nd == 14 && rx_data == CH_LF) begin m_in_frame = 1'b0; m_check = 1'b1; end
        else begin m_in_frame = 1'b0; exp_err = 1'b1; exp_code = 2'd1; end
      end else begin
        m_idle++;
        if (m_idle == TO_CYC) begin m_in_frame = 1'b0; exp_err = 1'b1; exp_code = 2'd3; end
      end
    end else if (rx_vld && rx_data == CH_S) begin
      m_in_frame = 1'b1; m_nd = 0; m_cr = 1'b0; m_idle = 0;
    end
    exp_busy = m_in_frame || m_check;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_ready) begin
      checkOutput("dout_vld", 64'(dout_vld), 64'(exp_vld));
      checkOutput("err", 64'(err), 64'(exp_err));
      checkOutput("err_code", 64'(err_code), 64'(exp_code));
      checkOutput("dout", 64'(dout), 64'(exp_dout));
      checkOutput("busy", 64'(busy), 64'(exp_busy));
      if (dout_vld) vld_seen++;
      if (err) err_seen++;
    end
  end

  // Called at a falling edge; leaves exactly 'idle' quiet cycles after the byte.
  task automatic applyStimulus(input logic [7:0] b, input int idle);
    rx_data = b;
    rx_vld  = 1'b1;
    @(negedge clk);
    rx_vld  = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  task automatic sendStr(input string s, input int idle);
    for (int i = 0; i < s.len(); i++) applyStimulus(s[i], idle);
  endtask

  task automatic sendFrame(input string d, input bit with_cr);
    applyStimulus(CH_S, 3);
    sendStr(d, 3);
    if (with_cr) applyStimulus(CH_CR, 3);
    applyStimulus(CH_LF, 4);
  endtask

  task automatic expectDelta(input string name, input int v0, input int e0,
                             input int dv, input int de);
    checkOutput({name, " vld count"}, 64'(vld_seen - v0), 64'(dv));
    checkOutput({name, " err count"}, 64'(err_seen - e0), 64'(de));
  endtask

  string bad [10] = '{"25081310246000", "25001231235959", "25081231235959",
                      "25071331235959", "25070031235959", "25071232235959",
                      "25071200235959", "25071231245959", "25071231236059",
                      "25071231235960"};

  initial begin
    int v0, e0;
    repeat (3) @(negedge clk);
    checkOutput("reset dout", 64'(dout), 64'h0);
    checkOutput("reset busy", 64'(busy), 64'h0);
    checkOutput("reset err_code", 64'(err_code), 64'h0);
    rst = 1'b0;
    @(negedge clk);

    v0 = vld_seen; e0 = err_seen;
    sendFrame("25031210123045", 1'b0);
    expectDelta("basic", v0, e0, 1, 0);
    checkOutput("basic dout", 64'(dout), 64'h25031210123045);

    // Month 15 is out of range, so this frame is rejected.
    v0 = vld_seen; e0 = err_seen;
    sendFrame("25031510123045", 1'b0);
    expectDelta("month15", v0, e0, 0, 1);
    checkOutput("month15 code", 64'(err_code), 64'h2);
    checkOutput("month15 dout held", 64'(dout), 64'h25031210123045);

    v0 = vld_seen; e0 = err_seen;
    sendStr("S2507123123595 9", 3);
    applyStimulus(CH_CR, 3);
    applyStimulus(CH_LF, 4);
    expectDelta("space", v0, e0, 0, 1);
    checkOutput("space code", 64'(err_code), 64'h1);
    sendFrame("25071231235959", 1'b1);
    checkOutput("crlf dout", 64'(dout), 64'h25071231235959);

    for (int i = 0; i < 10; i++) begin
      v0 = vld_seen; e0 = err_seen;
      sendFrame(bad[i], 1'b0);
      expectDelta("range", v0, e0, 0, 1);
      checkOutput("range code", 64'(err_code), 64'h2);
    end
    checkOutput("range dout held", 64'(dout), 64'h25071231235959);

    sendFrame("99070101000000", 1'b0);
    checkOutput("low edge dout", 64'(dout), 64'h99070101000000);

    v0 = vld_seen; e0 = err_seen;
    sendStr("S25031", 0);
    repeat (TO_CYC + 5) @(negedge clk);
    expectDelta("timeout", v0, e0, 0, 1);
    checkOutput("timeout code", 64'(err_code), 64'h3);
    checkOutput("timeout busy", 64'(busy), 64'h0);

    // A byte landing on the expiry cycle keeps the frame alive.
    v0 = vld_seen; e0 = err_seen;
    applyStimulus(CH_S, 3);
    sendStr("2507", 3);
    applyStimulus("1", TO_CYC - 1);
    sendStr("231235959", 3);
    applyStimulus(CH_LF, 4);
    expectDelta("expiry byte", v0, e0, 1, 0);

    v0 = vld_seen; e0 = err_seen;
    sendStr("S25S25031210123045", 3);
    applyStimulus(CH_LF, 4);
    sendStr("xyz", 3);
    expectDelta("restart", v0, e0, 1, 0);
    checkOutput("restart dout", 64'(dout), 64'h25031210123045);

    v0 = vld_seen; e0 = err_seen;
    sendStr("S25071231235959", 3);
    applyStimulus(CH_CR, 3);
    applyStimulus(CH_CR, 4);
    sendStr("S25071231235959", 3);
    applyStimulus("5", 4);
    sendStr("S25071231235959", 3);
    applyStimulus(CH_S, 4);
    expectDelta("term junk", v0, e0, 0, 3);

    v0 = vld_seen; e0 = err_seen;
    sendStr("S25071231", 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst busy", 64'(busy), 64'h0);
    repeat (3) @(negedge clk);
    expectDelta("rst", v0, e0, 0, 0);
    sendFrame("25031210123045", 1'b0);
    checkOutput("after rst dout", 64'(dout), 64'h25031210123045);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
